// File: rtl/regfile_cmd_ctrl.sv
// Purpose : byte-frame command sequencer from UART RX to the register file, read data returned to TX FIFO.
// Latency : write strobe 1 cycle after data byte; read RdEn at N+1, TX push at N+3 after address byte N.
// Backpr. : holds the read byte while TX_FULL is high, pushes the cycle after it drops; RX bytes are never stalled.
//
// Ports:
//   CLK, RST_n                    clock, asynchronous active-low reset
//   RX_P_DATA / RX_D_VLD          received byte and its one-cycle valid pulse
//   WrEn, RdEn, Address, WrData   register file strobes, address and write data (all registered)
//   RdData / RdData_valid         register file read return
//   TX_P_DATA / TX_D_VLD, TX_FULL byte and push strobe to the TX FIFO, FIFO full flag
//   busy, cmd_err                 not-idle flag, one-cycle protocol error pulse
// Optional: define CMD_BURST_RD_EN to add opcode 0xBC (addr, count) burst read.
module regfile_cmd_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int REG_FILE_DEPTH = 16,
  parameter int ADDR_WIDTH     = $clog2(REG_FILE_DEPTH),
  parameter int RD_TIMEOUT     = 4
) (
  input  logic                  CLK,
  input  logic                  RST_n,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic                  WrEn,
  output logic                  RdEn,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0] WrData,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_valid,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_FULL,
  output logic                  busy,
  output logic                  cmd_err
);

  localparam logic [DATA_WIDTH-1:0] OP_WR     = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] OP_RD     = DATA_WIDTH'(8'hBB);
  localparam int                    TW        = $clog2(RD_TIMEOUT) + 1;
  localparam logic [TW-1:0]         TMO_LAST  = TW'(RD_TIMEOUT - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(REG_FILE_DEPTH - 1);

`ifdef CMD_BURST_RD_EN
  localparam logic [DATA_WIDTH-1:0] OP_BRD = DATA_WIDTH'(8'hBC);
  localparam int STATE_W = 4;
`else
  localparam int STATE_W = 3;
`endif

  typedef enum logic [STATE_W-1:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_REQ, RD_WAIT, TX_SEND
`ifdef CMD_BURST_RD_EN
    , BR_ADDR, BR_CNT
`endif
  } state_t;

  state_t                state_q, state_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic                  tx_vld_q, tx_vld_d;
  logic                  busy_q, busy_d;
  logic                  cmd_err_q, cmd_err_d;
  logic [DATA_WIDTH-1:0] rd_byte_q, rd_byte_d;
  logic [TW-1:0]         tmo_q, tmo_d;
`ifdef CMD_BURST_RD_EN
  logic [DATA_WIDTH-1:0] burst_cnt_q, burst_cnt_d;  // reads remaining, including the one in flight
`endif

  logic                  addr_ok;
  logic                  push;
  logic [DATA_WIDTH-1:0] push_byte;

  assign addr_ok = ~|RX_P_DATA[DATA_WIDTH-1:ADDR_WIDTH];

  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    rd_en_d     = 1'b0;
    addr_d      = addr_q;
    wr_data_d   = wr_data_q;
    tx_data_d   = tx_data_q;
    tx_vld_d    = 1'b0;
    cmd_err_d   = 1'b0;
    rd_byte_d   = rd_byte_q;
    tmo_d       = tmo_q;
    push        = 1'b0;
    push_byte   = rd_byte_q;
`ifdef CMD_BURST_RD_EN
    burst_cnt_d = burst_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (RX_D_VLD) begin
          case (RX_P_DATA)
            OP_WR:   state_d = WR_ADDR;
            OP_RD:   state_d = RD_ADDR;
`ifdef CMD_BURST_RD_EN
            OP_BRD:  state_d = BR_ADDR;
`endif
            default: cmd_err_d = 1'b1;
          endcase
        end
      end
      WR_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            state_d = WR_DATA;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = IDLE;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            rd_en_d = 1'b1;          // strobe lands in RD_REQ, one cycle after the address byte
            state_d = RD_REQ;
`ifdef CMD_BURST_RD_EN
            burst_cnt_d = DATA_WIDTH'(1);
`endif
          end else begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
`ifdef CMD_BURST_RD_EN
      BR_ADDR: begin
        if (RX_D_VLD) begin
          if (addr_ok) begin
            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            state_d = BR_CNT;
          end else begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      BR_CNT: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == '0) begin
            cmd_err_d = 1'b1;
            state_d   = IDLE;
          end else begin
            burst_cnt_d = RX_P_DATA;
            rd_en_d     = 1'b1;
            state_d     = RD_REQ;
          end
        end
      end
`endif
      RD_REQ: begin
        if (RX_D_VLD) cmd_err_d = 1'b1;
        tmo_d   = '0;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (RX_D_VLD) cmd_err_d = 1'b1;
        if (RdData_valid) begin
          // Push straight from the return bus when the FIFO has room, so the nominal
          // path reaches TX one cycle after RdData_valid.
          if (!TX_FULL) begin
            push      = 1'b1;
            push_byte = RdData;
          end else begin
            rd_byte_d = RdData;
            state_d   = TX_SEND;
          end
        end else if (tmo_q == TMO_LAST) begin
          cmd_err_d = 1'b1;
          state_d   = IDLE;
`ifdef CMD_BURST_RD_EN
          burst_cnt_d = '0;
`endif
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      TX_SEND: begin
        if (RX_D_VLD) cmd_err_d = 1'b1;
        if (!TX_FULL) begin
          push      = 1'b1;
          push_byte = rd_byte_q;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      tx_vld_d  = 1'b1;
      tx_data_d = push_byte;
      state_d   = IDLE;
`ifdef CMD_BURST_RD_EN
      // Chain the next burst read right behind this push.
      if (burst_cnt_q > DATA_WIDTH'(1)) begin
        burst_cnt_d = burst_cnt_q - 1'b1;
        addr_d      = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
        rd_en_d     = 1'b1;
        state_d     = RD_REQ;
      end else begin
        burst_cnt_d = '0;
      end
`endif
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= IDLE;
      wr_en_q     <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      wr_data_q   <= '0;
      tx_data_q   <= '0;
      tx_vld_q    <= 1'b0;
      busy_q      <= 1'b0;
      cmd_err_q   <= 1'b0;
      rd_byte_q   <= '0;
      tmo_q       <= '0;
`ifdef CMD_BURST_RD_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      wr_data_q   <= wr_data_d;
      tx_data_q   <= tx_data_d;
      tx_vld_q    <= tx_vld_d;
      busy_q      <= busy_d;
      cmd_err_q   <= cmd_err_d;
      rd_byte_q   <= rd_byte_d;
      tmo_q       <= tmo_d;
`ifdef CMD_BURST_RD_EN
      burst_cnt_q <= burst_cnt_d;
`endif
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wr_data_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;
  assign busy      = busy_q;
  assign cmd_err   = cmd_err_q;

endmodule

// File: tb/tb_regfile_cmd_ctrl.sv
// Bench for regfile_cmd_ctrl: drives RX byte frames, models the register file
// (one-cycle read return, optional silence) and scoreboards WrEn / TX pushes.
module tb_regfile_cmd_ctrl;

  localparam int DW = 8;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic [DW-1:0] RX_P_DATA = '0;
  logic          RX_D_VLD = 1'b0;
  logic          WrEn, RdEn;
  logic [AW-1:0] Address;
  logic [DW-1:0] WrData;
  logic [DW-1:0] RdData = '0;
  logic          RdData_valid = 1'b0;
  logic [DW-1:0] TX_P_DATA;
  logic          TX_D_VLD;
  logic          TX_FULL = 1'b0;
  logic          busy, cmd_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0]    tx_exp_q[$];
  logic [AW+DW-1:0] wr_exp_q[$];

  logic [DW-1:0] rf_mem [16];
  logic          rf_respond = 1'b1;

  regfile_cmd_ctrl dut (
    .CLK(CLK), .RST_n(RST_n),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .RdData(RdData), .RdData_valid(RdData_valid),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_FULL(TX_FULL),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 CLK = ~CLK;

  // Register file model: stores writes, answers a read the cycle after RdEn.
  always @(posedge CLK) begin
    RdData_valid <= 1'b0;
    if (WrEn) rf_mem[Address] <= WrData;
    if (RdEn && rf_respond) begin
      RdData_valid <= 1'b1;
      RdData       <= rf_mem[Address];
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [DW-1:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    step();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic test_reset();
    RST_n = 1'b0;
    step();
    step();
    n_checks++;
    if ({WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, busy, cmd_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: WrEn=%b RdEn=%b Addr=%h WrData=%h TX=%h TXV=%b busy=%b err=%b, required all 0",
               WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, busy, cmd_err);
    end
    RST_n = 1'b1;
    step();
  endtask

  task automatic test_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int first;
    int cnt;
    int errs;
    logic [AW+DW-1:0] exp;
    first = -1; cnt = 0; errs = 0;
    wr_exp_q.push_back({a, d});
    send_byte(8'hAA);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: busy=%b, required 1", busy); end
    send_byte({{(DW-AW){1'b0}}, a});
    send_byte(d);
    for (int i = 0; i < 5; i++) begin
      if (WrEn === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
        n_checks++;
        if (wr_exp_q.size() == 0) begin
          n_fail++; $display("FAIL wr_unexpected: Addr=%h WrData=%h, no write expected", Address, WrData);
        end else begin
          exp = wr_exp_q.pop_front();
          if ({Address, WrData} !== exp) begin
            n_fail++; $display("FAIL wr_payload: Addr=%h WrData=%h, required Addr=%h WrData=%h",
                               Address, WrData, exp[AW+DW-1:DW], exp[DW-1:0]);
          end
        end
      end
      if (cmd_err === 1'b1) errs++;
      step();
    end
    n_checks++;
    if (first !== 0 || cnt !== 1) begin
      n_fail++; $display("FAIL wr_strobe: first WrEn at +%0d count %0d, required +0 count 1", first, cnt);
    end
    n_checks++;
    if (errs !== 0) begin n_fail++; $display("FAIL wr_no_err: cmd_err pulses %0d, required 0", errs); end
  endtask

  task automatic test_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
    int first;
    int cnt;
    int rd_cnt;
    int busy_bad;
    first = -1; cnt = 0; rd_cnt = 0; busy_bad = 0;
    tx_exp_q.push_back(d);
    send_byte(8'hBB);
    if (busy !== 1'b1) busy_bad++;
    send_byte({{(DW-AW){1'b0}}, a});
    // Now in cycle N+1 relative to the address byte.
    for (int i = 0; i < 6; i++) begin
      if (RdEn === 1'b1) rd_cnt++;
      if (i < 2 && busy !== 1'b1) busy_bad++;
      if (TX_D_VLD === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
        n_checks++;
        if (tx_exp_q.size() == 0) begin
          n_fail++; $display("FAIL rd_unexpected_push: TX=%h", TX_P_DATA);
        end else if (TX_P_DATA !== tx_exp_q[0]) begin
          n_fail++; $display("FAIL rd_data: TX=%h, required %h", TX_P_DATA, tx_exp_q.pop_front());
        end else begin
          void'(tx_exp_q.pop_front());
        end
      end
      if (i == 0) begin
        n_checks++;
        if (RdEn !== 1'b1 || WrEn !== 1'b0) begin
          n_fail++; $display("FAIL rd_strobe_time: RdEn=%b WrEn=%b at N+1, required 1/0", RdEn, WrEn);
        end
      end
      step();
    end
    n_checks++;
    if (rd_cnt !== 1) begin n_fail++; $display("FAIL rd_strobe_count: %0d, required 1", rd_cnt); end
    n_checks++;
    if (first !== 2 || cnt !== 1) begin
      n_fail++; $display("FAIL rd_latency: push at N+%0d count %0d, required N+3 count 1", first + 1, cnt);
    end
    n_checks++;
    if (busy_bad !== 0) begin n_fail++; $display("FAIL rd_busy: %0d low cycles before push, required 0", busy_bad); end
  endtask

  task automatic test_tx_backpressure();
    int early;
    int first;
    int cnt;
    early = 0; first = -1; cnt = 0;
    TX_FULL = 1'b1;
    tx_exp_q.push_back(8'h3C);
    send_byte(8'hBB);
    send_byte(8'h05);
    for (int i = 0; i < 10; i++) begin
      if (TX_D_VLD === 1'b1) early++;
      step();
    end
    n_checks++;
    if (early !== 0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL bp_hold: pushes while full %0d busy=%b, required 0 and 1", early, busy);
    end
    TX_FULL = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (TX_D_VLD === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
        n_checks++;
        if (tx_exp_q.size() == 0 || TX_P_DATA !== tx_exp_q[0]) begin
          n_fail++; $display("FAIL bp_data: TX=%h, required 3c", TX_P_DATA);
        end
        if (tx_exp_q.size() != 0) void'(tx_exp_q.pop_front());
      end
      step();
    end
    n_checks++;
    if (first !== 1 || cnt !== 1) begin
      n_fail++; $display("FAIL bp_release: push at +%0d count %0d, required +1 count 1", first, cnt);
    end
  endtask

  task automatic test_bad_opcode_and_addr();
    send_byte(8'h77);
    n_checks++;
    if (cmd_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bad_opcode: cmd_err=%b busy=%b, required 1 and 0", cmd_err, busy);
    end
    step();
    n_checks++;
    if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL bad_opcode_pulse: cmd_err=%b, required 0", cmd_err); end
    send_byte(8'hAA);
    send_byte(8'h1F);
    n_checks++;
    if (cmd_err !== 1'b1 || WrEn !== 1'b0 || busy !== 1'b0 || Address !== 4'h5) begin
      n_fail++; $display("FAIL bad_addr: cmd_err=%b WrEn=%b busy=%b Addr=%h, required 1 0 0 5",
                         cmd_err, WrEn, busy, Address);
    end
    step();
    n_checks++;
    if (cmd_err !== 1'b0 || WrEn !== 1'b0) begin
      n_fail++; $display("FAIL bad_addr_after: cmd_err=%b WrEn=%b, required 0 0", cmd_err, WrEn);
    end
  endtask

  task automatic test_rx_during_read();
    tx_exp_q.push_back(8'h3C);
    send_byte(8'hBB);
    send_byte(8'h05);
    send_byte(8'hAA);  // arrives during RD_REQ and must be dropped
    n_checks++;
    if (cmd_err !== 1'b1 || TX_D_VLD !== 1'b0) begin
      n_fail++; $display("FAIL drop_err: cmd_err=%b TXV=%b at N+2, required 1 0", cmd_err, TX_D_VLD);
    end
    step();
    n_checks++;
    if (TX_D_VLD !== 1'b1 || TX_P_DATA !== tx_exp_q[0] || cmd_err !== 1'b0) begin
      n_fail++; $display("FAIL drop_continue: TXV=%b TX=%h err=%b, required 1 %h 0",
                         TX_D_VLD, TX_P_DATA, cmd_err, tx_exp_q[0]);
    end
    void'(tx_exp_q.pop_front());
    step();
    n_checks++;
    if (busy !== 1'b0 || WrEn !== 1'b0) begin
      n_fail++; $display("FAIL drop_idle: busy=%b WrEn=%b, required 0 0", busy, WrEn);
    end
  endtask

  task automatic test_timeout();
    int first;
    int cnt;
    int tx;
    first = -1; cnt = 0; tx = 0;
    rf_respond = 1'b0;
    send_byte(8'hBB);
    send_byte(8'h03);
    for (int i = 0; i < 8; i++) begin
      if (cmd_err === 1'b1) begin
        cnt++;
        if (first < 0) begin
          first = i;
          n_checks++;
          if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: busy=%b at error, required 0", busy); end
        end
      end
      if (TX_D_VLD === 1'b1) tx++;
      step();
    end
    n_checks++;
    if (first !== 5 || cnt !== 1) begin
      n_fail++; $display("FAIL tmo_time: cmd_err at N+%0d count %0d, required N+6 count 1", first + 1, cnt);
    end
    n_checks++;
    if (tx !== 0 || Address !== 4'h3) begin
      n_fail++; $display("FAIL tmo_no_push: pushes %0d Addr=%h, required 0 and 3", tx, Address);
    end
    rf_respond = 1'b1;
  endtask

`ifdef CMD_BURST_RD_EN
  task automatic test_burst();
    int cnt;
    cnt = 0;
    tx_exp_q.push_back(8'hE1);
    tx_exp_q.push_back(8'hF2);
    tx_exp_q.push_back(8'h0A);
    send_byte(8'hBC);
    send_byte(8'h0E);
    send_byte(8'h03);
    for (int i = 0; i < 40; i++) begin
      if (TX_D_VLD === 1'b1) begin
        cnt++;
        n_checks++;
        if (tx_exp_q.size() == 0) begin
          n_fail++; $display("FAIL burst_extra: TX=%h", TX_P_DATA);
        end else if (TX_P_DATA !== tx_exp_q[0]) begin
          n_fail++; $display("FAIL burst_data: TX=%h, required %h", TX_P_DATA, tx_exp_q.pop_front());
        end else begin
          void'(tx_exp_q.pop_front());
        end
      end
      step();
    end
    n_checks++;
    if (cnt !== 3 || busy !== 1'b0) begin
      n_fail++; $display("FAIL burst_count: pushes %0d busy=%b, required 3 and 0", cnt, busy);
    end
    tx_exp_q.delete();
  endtask

  task automatic test_burst_reset();
    int tx;
    tx = 0;
    send_byte(8'hBC);
    send_byte(8'h0E);
    send_byte(8'h03);
    step();
    step();
    RST_n = 1'b0;
    #1;
    n_checks++;
    if ({WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, busy, cmd_err} !== '0) begin
      n_fail++; $display("FAIL burst_reset: WrEn=%b RdEn=%b Addr=%h WrData=%h TX=%h TXV=%b busy=%b err=%b, required all 0",
                         WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, busy, cmd_err);
    end
    step();
    RST_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (TX_D_VLD === 1'b1) tx++;
      step();
    end
    n_checks++;
    if (tx !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL burst_after_reset: pushes %0d busy=%b, required 0 and 0", tx, busy);
    end
  endtask
`else
  task automatic test_burst_opcode_invalid();
    send_byte(8'hBC);
    n_checks++;
    if (cmd_err !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL bc_invalid: cmd_err=%b busy=%b, required 1 and 0", cmd_err, busy);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_write(4'h5, 8'h3C);
    test_read(4'h5, 8'h3C);
    test_tx_backpressure();
    test_bad_opcode_and_addr();
    test_rx_during_read();
    test_timeout();
    test_write(4'h9, 8'hC5);
    test_read(4'h9, 8'hC5);
`ifdef CMD_BURST_RD_EN
    test_write(4'hE, 8'hE1);
    test_write(4'hF, 8'hF2);
    test_write(4'h0, 8'h0A);
    test_burst();
    test_burst_reset();
`else
    test_burst_opcode_invalid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule
